keypad_scanner: RTL

- Drives the 4 columns of the 4x4 matrix keypad and reads back the debounced row lines that module_Debounce produces.
- Encodes the single pressed key into a 4-bit code.
- Hands each code to the multiplier's operand-entry logic through a valid/ack handshake.
- Emits exactly one code per physical press; a new code is accepted only after all keys are released.

---
 rtl/keypad_pkg.sv | 20 ++
 rtl/keypad_decode.sv | 12 +
 rtl/keypad_scanner.sv | 80 ++++++++
 3 files changed

// File: rtl/keypad_pkg.sv
// keypad_pkg: FSM states, key codes and the 4x4 key lookup shared by the keypad scanner
package keypad_pkg;
  typedef enum logic [1:0] {SCAN, CONFIRM, VALID, RELEASE} state_t;
  localparam logic [3:0] KEY_A = 4'hA;
  localparam logic [3:0] KEY_B = 4'hB;
  localparam logic [3:0] KEY_C = 4'hC;
  localparam logic [3:0] KEY_D = 4'hD;
  localparam logic [3:0] KEY_STAR = 4'hE;
  localparam logic [3:0] KEY_HASH = 4'hF;
  localparam logic [3:0] NO_KEY = 4'b1111;
  function automatic logic [1:0] one_cold_idx(input logic [3:0] v);
    return !v[0] ? 2'd0 : !v[1] ? 2'd1 : !v[2] ? 2'd2 : 2'd3;
  endfunction
  // Rows 0..2 of columns 0..2 are the digits 1..9; column 3 holds A..D; row 3 is *,0,#,D.
  function automatic logic [3:0] key_lookup(input logic [1:0] r, input logic [1:0] c);
    return r == 2'd3 ? (c == 2'd0 ? KEY_STAR : c == 2'd1 ? 4'h0 : c == 2'd2 ? KEY_HASH : KEY_D)
         : c == 2'd3 ? KEY_A + {2'b00, r}
         : {2'b00, r} * 4'd3 + {2'b00, c} + 4'd1;
  endfunction
endpackage

// File: rtl/keypad_decode.sv
// keypad_decode: maps a one-cold row and column pair to a key code; ports row, col in, code and onehot_ok out
module keypad_decode
  import keypad_pkg::*;
(
  input  logic [3:0] row,
  input  logic [3:0] col,
  output logic [3:0] code,
  output logic       onehot_ok
);
  assign code = key_lookup(one_cold_idx(row), one_cold_idx(col));
  assign onehot_ok = ($countones(~row) == 1) && ($countones(~col) == 1);
endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 keypad, confirms one press, hands its code out via valid/ack; ports clk, rst_n, filas_in, columnas_out, key_code, key_valid, key_ack
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4,
  parameter int CONFIRM_CYCLES = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] filas_in,
  output logic [3:0] columnas_out,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_ack
);
  state_t state;
  logic [1:0] col;
  logic [7:0] cnt;
  logic [3:0] pat;
  logic [3:0] dec_code;
  logic       dec_ok;
  assign columnas_out = ~(4'b0001 << col);
  // In SCAN the live rows are qualified; afterwards the latched pattern drives the code.
  keypad_decode u_dec (
    .row       (state == SCAN ? filas_in : pat),
    .col       (columnas_out),
    .code      (dec_code),
    .onehot_ok (dec_ok)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= SCAN;
      col <= 2'd0;
      cnt <= 8'd0;
      pat <= NO_KEY;
      key_code <= 4'h0;
      key_valid <= 1'b0;
    end else begin
      case (state)
        SCAN: begin
          if (cnt == 8'(SETTLE_CYCLES - 1)) begin
            cnt <= 8'd0;
            if (dec_ok) begin
              pat <= filas_in;
              state <= CONFIRM;
            end else col <= col + 2'd1;
          end else cnt <= cnt + 8'd1;
        end
        CONFIRM: begin
          // Emission takes one edge after the last matching sample.
          if (cnt == 8'(CONFIRM_CYCLES)) begin
            key_code <= dec_code;
            key_valid <= 1'b1;
            cnt <= 8'd0;
            state <= VALID;
          end else if (filas_in == pat) cnt <= cnt + 8'd1;
          else begin
            cnt <= 8'd0;
            col <= col + 2'd1;
            state <= SCAN;
          end
        end
        VALID: begin
          if (key_ack) begin
            key_valid <= 1'b0;
            state <= RELEASE;
          end
        end
        RELEASE: begin
          if (filas_in != NO_KEY) cnt <= 8'd0;
          else if (cnt == 8'(CONFIRM_CYCLES - 1)) begin
            cnt <= 8'd0;
            col <= 2'd0;
            state <= SCAN;
          end else cnt <= cnt + 8'd1;
        end
      endcase
    end
  end
endmodule
